// File: rtl/cpu_in_port_pkg.sv
// Shared CPU constants for the input port: nibble width and default FIFO depth,
// kept here so the port always matches the CPU data path.
package cpu_in_port_pkg;

  localparam int CPU_NIBBLE_W = 4;
  localparam int CPU_IN_DEPTH = 4;

  // Width of an occupancy counter able to hold the value 'depth'.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cpu_in_fifo.sv
// Storage array plus read/write pointers and occupancy counter for the CPU input port.
// The head entry is presented combinationally; an empty FIFO presents zero.
module cpu_in_fifo
  import cpu_in_port_pkg::*;
#(
  parameter int DEPTH  = CPU_IN_DEPTH,
  parameter int DATA_W = CPU_NIBBLE_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             head_data,
  output logic                          empty,
  output logic                          full,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push_s;
  logic              do_pop_s;

  assign empty = (count_q == CNT_W'(0));
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  // Guard the requests here too, so the counter can never leave 0..DEPTH.
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entries are unreachable after reset, so the array itself is never cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = empty ? DATA_W'(0) : mem_q[rd_ptr_q];

endmodule

// File: rtl/cpu_in_port.sv
// External producer input port for the CPU: valid/ready push side, ein-driven pop
// side toward the bus mux, and a registered underflow pulse for ein on an empty FIFO.
module cpu_in_port
  import cpu_in_port_pkg::*;
#(
  parameter int DEPTH  = CPU_IN_DEPTH,
  parameter int DATA_W = CPU_NIBBLE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        ein,
  output logic [DATA_W-1:0]           port_data,
  output logic                        empty,
  output logic                        full,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        underflow
);

  logic push_s;
  logic pop_s;
  logic underflow_q, underflow_d;

  // Ready depends only on occupancy; a pop in the same cycle does not free a slot early.
  assign in_ready = !full;
  assign push_s   = in_valid && in_ready;
  assign pop_s    = ein && !empty;

  cpu_in_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (in_data),
    .pop       (pop_s),
    .head_data (port_data),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  always_comb begin
    underflow_d = 1'b0;
    if (ein && empty) begin
      underflow_d = 1'b1;
    end else begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign underflow = underflow_q;

endmodule

// File: tb/tb_cpu_in_port.sv
// Directed and random stimulus for cpu_in_port, checked against a queue model.
module tb_cpu_in_port;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 4;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ein;
  logic [DATA_W-1:0] port_data;
  logic              empty;
  logic              full;
  logic [2:0]        count;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model_q[$];
  logic              model_uf;

  cpu_in_port #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ein       (ein),
    .port_data (port_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_head;
    exp_head = (model_q.size() == 0) ? 32'd0 : 32'(model_q[0]);
    chk({tag, "_count"}, 32'(count), 32'(model_q.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
    chk({tag, "_full"}, 32'(full), 32'(model_q.size() == DEPTH));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(model_q.size() != DEPTH));
    chk({tag, "_port_data"}, 32'(port_data), exp_head);
    chk({tag, "_underflow"}, 32'(underflow), 32'(model_uf));
  endtask

  // One clock cycle: drive at negedge, apply model at posedge, check at next negedge.
  task automatic cycle(input string tag, input logic v, input logic [DATA_W-1:0] d, input logic e);
    bit do_push;
    bit do_pop;
    in_valid = v;
    in_data  = d;
    ein      = e;
    #1;
    if (e && model_q.size() > 0) chk({tag, "_pop_head"}, 32'(port_data), 32'(model_q[0]));
    @(posedge clk);
    do_push  = v && (model_q.size() < DEPTH);
    do_pop   = e && (model_q.size() > 0);
    model_uf = e && (model_q.size() == 0);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ein      = 1'b0;
    model_uf = 1'b0;
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // First edge after reset accepts a push, visible the next cycle.
    cycle("push3", 1'b1, 4'h3, 1'b0);
    cycle("drain3", 1'b0, 4'h0, 1'b1);

    // Fill to full, then a fifth push must be ignored.
    for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, DATA_W'(i), 1'b0);
    cycle("push_full", 1'b1, 4'h5, 1'b0);
    chk("full_count_stays4", 32'(count), 32'd4);

    // Pop four times; head is checked just before each pop edge.
    for (int i = 0; i < 4; i++) cycle("pop", 1'b0, 4'h0, 1'b1);
    chk("drained_port_data", 32'(port_data), 32'd0);

    // Underflow: one-cycle pulse, no state change.
    cycle("uf_on", 1'b0, 4'h0, 1'b1);
    cycle("uf_off", 1'b0, 4'h0, 1'b0);

    // Simultaneous push and pop at count 2.
    cycle("pre_b", 1'b1, 4'hB, 1'b0);
    cycle("pre_c", 1'b1, 4'hC, 1'b0);
    cycle("push_pop", 1'b1, 4'hA, 1'b1);
    cycle("after_pp1", 1'b0, 4'h0, 1'b1);
    cycle("after_pp2", 1'b0, 4'h0, 1'b1);

    // Force pointer wrap (5 pushes, 3 pops), then reset between edges.
    for (int i = 0; i < 4; i++) cycle("wrap_push", 1'b1, DATA_W'(4'h6 + i), 1'b0);
    for (int i = 0; i < 3; i++) cycle("wrap_pop", 1'b0, 4'h0, 1'b1);
    cycle("wrap_push5", 1'b1, 4'hE, 1'b0);
    cycle("wrap_pp", 1'b1, 4'hF, 1'b1);
    #2;
    rst = 1'b0;
    model_q.delete();
    model_uf = 1'b0;
    #1;
    check_all("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    cycle("post_reset_push", 1'b1, 4'h9, 1'b0);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
